alu_multicycle: RTL
===================

# alu_multicycle

Multi-cycle integer ALU for the RV32 core, directly downstream of the ALU controller. It consumes the controller's 3-bit `alu_control` code plus two operands under a valid/ready handshake. Arithmetic and logic operations complete in one cycle; shifts iterate one bit per cycle. It returns a registered result and a zero flag, which the branch logic uses for BEQ/BNE.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `SHW`, default `$clog2(XLEN)`: shift-amount width, 5 for RV32.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: the request fields below are valid.
- `in_ready`  out  1: the block accepts a request this cycle.
- `alu_control`  in  3: operation code. 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SRL, 110 SLL, 111 reserved.
- `operand_a`  in  XLEN: rs1 value.
- `operand_b`  in  XLEN: rs2 value or immediate.
- `out_valid`  out  1: `result` and `zero` are valid.
- `out_ready`  in  1: the consumer takes the result this cycle.
- `result`  out  XLEN: registered result.
- `zero`  out  1: high when `result` equals 0, registered together with `result`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- A request is accepted when `in_valid && in_ready`. On acceptance, `alu_control`, the operands and the shift amount `operand_b[SHW-1:0]` are captured. Upper bits of `operand_b` are ignored for shifts.
- IDLE, accepting ADD/SUB/AND/OR/XOR:
  - The result is computed combinationally and registered.
  - The FSM moves to DONE.
  - ADD and SUB wrap modulo 2^XLEN; no carry or overflow output.
- IDLE, accepting SRL/SLL:
  - If the shift amount is 0, the result is `operand_a` and the FSM moves straight to DONE.
  - Otherwise the accumulator is loaded with `operand_a`, the counter with the shift amount, and the FSM moves to SHIFT.
- SHIFT:
  - Each cycle the accumulator shifts by 1 bit, zero-filled (SRL logical right, SLL left), and the counter decrements.
  - On the cycle the counter goes from 1 to 0, the final value and `zero` are registered and the FSM moves to DONE.
  - In SHIFT, `in_ready` is 0 and `in_valid` is ignored.
- Reserved code 111: result 0, `zero` = 1, one-cycle path. This is not an error.
- DONE:
  - `out_valid` = 1; `result` and `zero` hold stable until `out_ready`.
  - On `out_ready`: if `in_valid` is also high, the new request is accepted in the same cycle (back-to-back) and the FSM follows the IDLE acceptance rules. Otherwise the FSM moves to IDLE.
- `in_ready` = !rst && (state==IDLE || (state==DONE && out_ready)).
- Operand or control changes on the inputs after acceptance have no effect on the operation in flight.

## Timing
- Reset values: `out_valid` 0, `result` 0, `zero` 0, counter 0, state IDLE. `in_ready` is 0 while `rst` is high and 1 on the first cycle after reset is released.
- Reset asserted mid-SHIFT or in DONE: the operation is abandoned, no `out_valid` is produced, and state is IDLE on the next edge.
- Latency, accept edge to first `out_valid` cycle:
  - ADD/SUB/AND/OR/XOR/111, and shifts by 0: 1 cycle.
  - Shifts by n > 0: n+1 cycles. The maximum is XLEN for a shift by XLEN-1.
- Throughput: one op per cycle for single-cycle ops when `out_ready` is held high; no idle bubble between ops.
- `out_valid` never drops without `out_ready`. `result` and `zero` do not change while `out_valid && !out_ready`.
- Back-pressure in DONE stalls the block indefinitely with no loss of data.

## Structure
- Shared header `alu_defs.vh`, guarded with ifndef, containing:
  - The opcode constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_SRL=101, ALU_SLL=110, ALU_RSVD=111.
  - FSM state encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - The ALU controller includes the same header so both blocks use one code table.
- One sub-module, `alu_logic_unit`: combinational ADD/SUB/AND/OR/XOR/reserved datapath, XLEN-parameterised.
- The FSM, shift accumulator, counter and output registers stay in the top module.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_valid` high. Required: `in_ready` 0, `out_valid` 0, `result` 0 throughout. After release, `in_ready` is 1.
- ADD wrap and SUB zero:
  - ADD 0xFFFFFFFF + 0x00000001: `result` 0x00000000, `zero` 1, one cycle after accept.
  - SUB 5 - 5: `zero` 1.
  - SUB 5 - 3: `result` 2, `zero` 0.
- Shifts:
  - SLL 0x00000001 by 31: `result` 0x80000000, `out_valid` 32 cycles after accept, `in_ready` low meanwhile.
  - SRL 0x80000000 by `operand_b`=0x00000024 (amount 4): `result` 0x08000000 after 5 cycles.
  - Shift by 0: `result` equals `operand_a` after 1 cycle.
- Back-pressure: hold `out_ready` low for 10 cycles after AND 0xF0F0F0F0 & 0xFF00FF00. Required: `result` 0xF000F000 stable, `in_ready` 0. Raise `out_ready` with `in_valid` (XOR 1^1): accepted same cycle; next cycle `result` 0, `zero` 1.
- Reset mid-shift: assert `rst` during cycle 5 of an SLL by 20. Required: no `out_valid` ever for that op; IDLE next cycle; a following ADD 2+3 returns 5.
- Streaming: 8 back-to-back OR ops with `out_ready` high. Required: 8 consecutive `out_valid` cycles with results in order, `in_ready` constantly 1.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// ---------------------------------------------------------------------------
// alu_multicycle_pkg
//   Shared definitions for the multi-cycle ALU and its controller:
//   - 3-bit operation code table (one table for both blocks)
//   - FSM state type of the ALU sequencer
//   - small helper to classify shift operations
// ---------------------------------------------------------------------------
package alu_multicycle_pkg;

  // Operation codes driven by the ALU controller on alu_control.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the two iterative (bit-serial) operations.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_multicycle_logic.sv
// ---------------------------------------------------------------------------
// alu_logic_unit
//   Combinational single-cycle datapath of the multi-cycle ALU.
//   Covers ADD/SUB (modulo 2^XLEN, no carry/overflow), AND, OR, XOR and the
//   reserved code, which yields 0. Shift codes also yield 0 here; shifts are
//   sequenced by the top level.
//
// Ports:
//   alu_control  in  3     operation code
//   operand_a    in  XLEN  first operand
//   operand_b    in  XLEN  second operand
//   y            out XLEN  combinational result
// ---------------------------------------------------------------------------
module alu_logic_unit
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    unique case (alu_control)
      ALU_ADD: y = operand_a + operand_b;
      ALU_SUB: y = operand_a - operand_b;
      ALU_AND: y = operand_a & operand_b;
      ALU_OR:  y = operand_a | operand_b;
      ALU_XOR: y = operand_a ^ operand_b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Multi-cycle integer ALU sitting downstream of the ALU controller.
//   Logic/arithmetic ops finish in one cycle; SRL/SLL shift one bit per
//   cycle. Result and zero flag are registered and held under a
//   valid/ready handshake on both sides.
//
// Ports:
//   clk          in  1     clock, rising edge
//   rst          in  1     synchronous active-high reset
//   in_valid     in  1     request fields valid
//   in_ready     out 1     request accepted this cycle when in_valid is high
//   alu_control  in  3     operation code (see alu_multicycle_pkg)
//   operand_a    in  XLEN  rs1 value
//   operand_b    in  XLEN  rs2 value or immediate; low SHW bits = shift amount
//   out_valid    out 1     result/zero valid
//   out_ready    in  1     consumer takes the result this cycle
//   result       out XLEN  registered result
//   zero         out 1     registered (result == 0)
// ---------------------------------------------------------------------------
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e          state;
  logic [2:0]      op_reg;     // captured op, selects shift direction
  logic [XLEN-1:0] acc;        // shift accumulator
  logic [SHW-1:0]  cnt;        // remaining shift steps

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] logic_y;
  logic [XLEN-1:0] single_val; // result of any op that completes on accept
  logic            start_shift;
  logic [XLEN-1:0] acc_step;

  alu_logic_unit #(
    .XLEN (XLEN)
  ) u_logic (
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .y           (logic_y)
  );

  assign in_ready = !rst && ((state == ST_IDLE) ||
                             ((state == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = operand_b[SHW-1:0];

  always_comb begin
    start_shift = is_shift_op(alu_control) && (shamt != '0);
    // Shift by zero passes operand_a straight through as a one-cycle op.
    single_val  = is_shift_op(alu_control) ? operand_a : logic_y;
    acc_step    = (op_reg == ALU_SRL) ? {1'b0, acc[XLEN-1:1]}
                                      : {acc[XLEN-2:0], 1'b0};
  end

  // Acceptance is only possible in IDLE, or in DONE while the current result
  // is being consumed, so it is handled ahead of the per-state behaviour and
  // covers the back-to-back case with the same code as a fresh start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_reg    <= ALU_ADD;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      op_reg <= alu_control;
      if (start_shift) begin
        acc       <= operand_a;
        cnt       <= shamt;
        out_valid <= 1'b0;
        state     <= ST_SHIFT;
      end else begin
        result    <= single_val;
        zero      <= (single_val == '0);
        out_valid <= 1'b1;
        state     <= ST_DONE;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
        end
        ST_SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result    <= acc_step;
            zero      <= (acc_step == '0);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result is held until taken; no new request arrived with out_ready.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
